// File: rtl/isquare.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : isquare                                                    |
// | Description : Iterative shift-add squarer, y = a*a for an unsigned       |
// |               IN_W-bit operand. One conditional add per clock, fixed     |
// |               latency of IN_W+1 clocks from the accept edge. Result is   |
// |               held in a register until the next completion.              |
// | Options     : ISQR_DONE_EN - when defined, adds the registered one-cycle |
// |               done_out completion pulse.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module isquare #(
    parameter int IN_W = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [IN_W-1:0]     a_in,
    input  logic                start_in,
    output logic                busy_out,
    output logic [2*IN_W-1:0]   y_out
`ifdef ISQR_DONE_EN
    ,
    output logic                done_out
`endif
);

    localparam int          c_CTR_W   = $clog2(IN_W + 1);
    localparam logic [0:0]  c_ST_IDLE = 1'b0;
    localparam logic [0:0]  c_ST_WORK = 1'b1;

    logic [0:0]             r_state;
    logic [2*IN_W-1:0]      r_acc;
    logic [2*IN_W-1:0]      r_mcand;
    logic [IN_W-1:0]        r_mplr;
    logic [c_CTR_W-1:0]     r_ctr;
    logic [2*IN_W-1:0]      r_y;
`ifdef ISQR_DONE_EN
    logic                   r_done;
`endif

    // Control FSM and shift-add datapath: accept in IDLE, IN_W add steps, then publish.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= c_ST_IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_ctr   <= '0;
            r_y     <= '0;
`ifdef ISQR_DONE_EN
            r_done  <= 1'b0;
`endif
        end else begin
`ifdef ISQR_DONE_EN
            // Pulse defaults low; raised only on the completion edge below.
            r_done <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (start_in) begin
                        r_mcand <= {{IN_W{1'b0}}, a_in};
                        r_mplr  <= a_in;
                        r_acc   <= '0;
                        r_ctr   <= c_CTR_W'(IN_W);
                        r_state <= c_ST_WORK;
                    end
                end
                c_ST_WORK: begin
                    if (r_ctr != '0) begin
                        // Partial product for the current multiplier bit; the
                        // running sum never exceeds (2^IN_W-1)^2 so no wrap.
                        if (r_mplr[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= r_mcand << 1;
                        r_mplr  <= r_mplr >> 1;
                        r_ctr   <= r_ctr - 1'b1;
                    end else begin
                        r_y     <= r_acc;
                        r_state <= c_ST_IDLE;
`ifdef ISQR_DONE_EN
                        r_done  <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy_out = (r_state == c_ST_WORK);
    assign y_out    = r_y;
`ifdef ISQR_DONE_EN
    assign done_out = r_done;
`endif

endmodule
`default_nettype wire
